// File: rtl/nibble_sel_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_sel_scheduler                                                       |
// | Table-driven sequencer that replays lane-select entries to the selector    |
// | bank under a valid/ready handshake, for N passes or continuously.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nibble_sel_scheduler #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [27:0]      cfg_data,
  input  logic [AW-1:0]    prog_last,
  input  logic [CNT_W-1:0] loops,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             sel_valid,
  output logic [11:0]      selA_o,
  output logic [11:0]      selB_o,
  output logic [3:0]       sel_o,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [27:0]      r_table [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    r_last;
  logic [CNT_W-1:0] r_passes;
  logic             r_valid;
  logic [11:0]      r_sel_a;
  logic [11:0]      r_sel_b;
  logic [3:0]       r_sel;

  logic             w_idle;
  logic             w_run;
  logic             w_launch;
  logic             w_xfer;
  logic             w_at_last;
  logic             w_final;
  logic             w_advance;
  logic             w_wrap;
  logic             w_finish;
  logic             w_load;
  logic             w_tbl_we;
  logic [AW-1:0]    w_load_idx;
  logic [27:0]      w_entry;
  logic [11:0]      w_load_a;
  logic [11:0]      w_load_b;
  logic [3:0]       w_load_s;
  logic             w_valid_nxt;

  // Control decode; abort outranks every other transition while busy.
  assign w_idle    = (r_state == c_st_idle);
  assign w_run     = (r_state == c_st_run);
  assign w_tbl_we  = w_idle & cfg_we;
  assign w_launch  = w_idle & start & ~cfg_we & ~abort;
  assign w_xfer    = w_run & r_valid & out_ready & ~abort;
  assign w_at_last = (r_ptr == r_last);
  // A pass count of zero means continuous replay; finite runs stop at one.
  assign w_final   = (r_passes == CNT_W'(1));
  assign w_advance = w_xfer & ~w_at_last;
  assign w_wrap    = w_xfer & w_at_last & ~w_final;
  assign w_finish  = w_xfer & w_at_last & w_final;
  assign w_load    = w_launch | w_advance | w_wrap;
  assign w_load_idx = w_advance ? (r_ptr + AW'(1)) : '0;
  assign w_entry   = r_table[w_load_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_load_a[3*gi+2:3*gi] = w_entry[7*gi+2:7*gi];
      assign w_load_b[3*gi+2:3*gi] = w_entry[7*gi+5:7*gi+3];
      assign w_load_s[gi]          = w_entry[7*gi+6];
    end
  endgenerate

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_launch) begin
      w_valid_nxt = 1'b1;
    end else if (!w_idle && abort) begin
      w_valid_nxt = 1'b0;
    end else if (w_finish) begin
      w_valid_nxt = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_launch) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        if (abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_finish) begin
          w_state_nxt = c_st_done;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_st_run: begin
        busy = 1'b1;
      end
      c_st_done: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Table storage: writable only while idle, frozen during a run.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_tbl_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // Sequencing pointer and pass counter
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_ptr    <= '0;
      r_last   <= '0;
      r_passes <= '0;
    end else if (w_launch) begin
      r_ptr    <= '0;
      r_last   <= prog_last;
      r_passes <= loops;
    end else if (w_advance) begin
      r_ptr <= r_ptr + AW'(1);
    end else if (w_wrap) begin
      r_ptr <= '0;
      if (r_passes != '0) begin
        r_passes <= r_passes - CNT_W'(1);
      end
    end
  end

  // Select outputs change only on a load; dropping valid leaves them intact.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_valid <= 1'b0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_sel   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_sel_a <= w_load_a;
        r_sel_b <= w_load_b;
        r_sel   <= w_load_s;
      end
    end
  end

  assign sel_valid = r_valid;
  assign selA_o    = r_sel_a;
  assign selB_o    = r_sel_b;
  assign sel_o     = r_sel;

endmodule
`default_nettype wire
